// File: rtl/pixel_window_buffer.sv
// 3x3 sliding-window generator: two line buffers plus a 3-column shift register
// turn a row-major pixel stream into one neighbourhood per interior pixel.
module pixel_window_buffer #(
  parameter int PIXEL_W   = 8,
  parameter int NUM_CH    = 3,
  parameter int MAX_WIDTH = 2500,
  parameter int DIM_W     = 16
) (
  input  logic                          clk,
  input  logic                          n_rst,
  input  logic                          start,
  input  logic                          clear,
  input  logic [DIM_W-1:0]              img_width,
  input  logic [DIM_W-1:0]              img_height,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [NUM_CH*PIXEL_W-1:0]     in_pixel,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [9*NUM_CH*PIXEL_W-1:0]   out_window,
  output logic [DIM_W-1:0]              out_x,
  output logic [DIM_W-1:0]              out_y,
  output logic                          out_last,
  output logic                          frame_done,
  output logic                          busy,
  output logic                          cfg_error
);

  localparam int PX_W = NUM_CH * PIXEL_W;
  localparam int AW   = (MAX_WIDTH > 1) ? $clog2(MAX_WIDTH) : 1;
  localparam logic [DIM_W-1:0] MIN_DIM = DIM_W'(3);
  localparam logic [DIM_W-1:0] MAX_DIM = DIM_W'(MAX_WIDTH);
  localparam logic [DIM_W-1:0] ONE     = DIM_W'(1);
  localparam logic [DIM_W-1:0] TWO     = DIM_W'(2);

  typedef enum logic [1:0] {S_IDLE, S_STREAM, S_FLUSH} state_t;

  state_t state, state_next;

  logic [DIM_W-1:0] width_q, height_q, col, row;
  logic             accept, produce, last_px, out_fire, legal_dims, start_idle;
  logic [AW-1:0]    lb_addr;
  logic [PX_W-1:0]  lb0 [MAX_WIDTH];
  logic [PX_W-1:0]  lb1 [MAX_WIDTH];
  logic [PX_W-1:0]  lb_a, lb_b;
  logic [PX_W-1:0]  win_c0 [3];
  logic [PX_W-1:0]  win_c1 [3];
  logic [PX_W-1:0]  new_col [3];
  logic [9*PX_W-1:0] window_next;

  assign in_ready   = (state == S_STREAM) && (!out_valid || out_ready);
  assign accept     = in_ready && in_valid;
  assign out_fire   = out_valid && out_ready;
  assign busy       = (state != S_IDLE);
  assign legal_dims = (img_width >= MIN_DIM) && (img_width <= MAX_DIM) && (img_height >= MIN_DIM);
  assign start_idle = (state == S_IDLE) && start;
  assign produce    = (row >= TWO) && (col >= TWO);
  assign last_px    = (col == width_q - ONE) && (row == height_q - ONE);
  assign lb_addr    = col[AW-1:0];
  assign lb_a       = lb0[lb_addr];
  assign lb_b       = lb1[lb_addr];

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) state <= S_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (clear) begin
      state_next = S_IDLE;
    end else begin
      case (state)
        S_IDLE:   if (start && legal_dims) state_next = S_STREAM;
        S_STREAM: if (accept && last_px)   state_next = S_FLUSH;
        S_FLUSH:  if (out_fire && out_last) state_next = S_IDLE;
        default:  state_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      width_q  <= '0;
      height_q <= '0;
      col      <= '0;
      row      <= '0;
    end else if (clear) begin
      col <= '0;
      row <= '0;
    end else if (start_idle && legal_dims) begin
      width_q  <= img_width;
      height_q <= img_height;
      col      <= '0;
      row      <= '0;
    end else if (accept) begin
      if (col == width_q - ONE) begin
        col <= '0;
        row <= row + ONE;
      end else begin
        col <= col + ONE;
      end
    end
  end

  // Read-before-write: the old row-1 pixel moves down to row-2 as the new pixel lands.
  always_ff @(posedge clk) begin
    if (accept) begin
      lb1[lb_addr] <= lb_a;
      lb0[lb_addr] <= in_pixel;
    end
  end

  always_comb begin
    new_col[0] = lb_b;
    new_col[1] = lb_a;
    new_col[2] = in_pixel;
    window_next = '0;
    for (int r = 0; r < 3; r++) begin
      window_next[(3*r+0)*PX_W +: PX_W] = win_c0[r];
      window_next[(3*r+1)*PX_W +: PX_W] = win_c1[r];
      window_next[(3*r+2)*PX_W +: PX_W] = new_col[r];
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      for (int r = 0; r < 3; r++) begin
        win_c0[r] <= '0;
        win_c1[r] <= '0;
      end
    end else if (accept) begin
      win_c0 <= win_c1;
      win_c1 <= new_col;
    end
  end

  // Single output slot; a new window may load in the same cycle the old one is taken.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      out_valid  <= 1'b0;
      out_window <= '0;
      out_x      <= '0;
      out_y      <= '0;
      out_last   <= 1'b0;
      frame_done <= 1'b0;
      cfg_error  <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      cfg_error  <= 1'b0;
      if (clear) begin
        out_valid <= 1'b0;
        out_last  <= 1'b0;
      end else begin
        if (start_idle && !legal_dims) cfg_error <= 1'b1;
        if (out_fire && out_last)      frame_done <= 1'b1;
        if (accept && produce) begin
          out_valid  <= 1'b1;
          out_window <= window_next;
          out_x      <= col - ONE;
          out_y      <= row - ONE;
          out_last   <= last_px;
        end else if (out_fire) begin
          out_valid <= 1'b0;
          out_last  <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_pixel_window_buffer.sv
// Self-checking bench: frames of random or raster pixels against a neighbourhood model.
module tb_pixel_window_buffer;

  localparam int PIXEL_W = 8;
  localparam int NUM_CH  = 3;
  localparam int PX_W    = PIXEL_W * NUM_CH;
  localparam int WIN_W   = 9 * PX_W;
  localparam int DIM_W   = 16;
  localparam int MAXW    = 64;

  typedef struct {
    logic [WIN_W-1:0] win;
    logic [DIM_W-1:0] x;
    logic [DIM_W-1:0] y;
    logic             last;
  } win_t;

  logic tb_clk = 1'b0;
  always #5 tb_clk = ~tb_clk;

  logic              n_rst, start, clear, in_valid, in_ready, out_valid, out_ready;
  logic [DIM_W-1:0]  img_width, img_height, out_x, out_y;
  logic [PX_W-1:0]   in_pixel;
  logic [WIN_W-1:0]  out_window;
  logic              out_last, frame_done, busy, cfg_error;

  int checks = 0;
  int errors = 0;

  pixel_window_buffer #(
    .PIXEL_W(PIXEL_W), .NUM_CH(NUM_CH), .MAX_WIDTH(MAXW), .DIM_W(DIM_W)
  ) dut (
    .clk(tb_clk), .n_rst(n_rst), .start(start), .clear(clear),
    .img_width(img_width), .img_height(img_height),
    .in_valid(in_valid), .in_ready(in_ready), .in_pixel(in_pixel),
    .out_valid(out_valid), .out_ready(out_ready), .out_window(out_window),
    .out_x(out_x), .out_y(out_y), .out_last(out_last),
    .frame_done(frame_done), .busy(busy), .cfg_error(cfg_error)
  );

  task automatic do_start(input int w, input int h);
    start      = 1'b1;
    img_width  = DIM_W'(w);
    img_height = DIM_W'(h);
    @(negedge tb_clk);
    start = 1'b0;
  endtask

  // Runs one whole frame; every window is checked against a model built from the image array.
  task automatic run_frame(input int w, input int h, input int pix_mode, input int rdy_mode, input string name);
    logic [PX_W-1:0] img[$];
    win_t expq[$];
    win_t e, held;
    int   idx, nwin, cyc, budget, px, py;
    logic fd_exp, valid_exp, hold_prev, finished, fire_last;
    for (int i = 0; i < w*h; i++)
      img.push_back(pix_mode == 0 ? {NUM_CH{PIXEL_W'(i)}} : PX_W'($urandom));
    for (int y = 1; y < h-1; y++)
      for (int x = 1; x < w-1; x++) begin
        e.win = '0;
        for (int r = 0; r < 3; r++)
          for (int c = 0; c < 3; c++)
            e.win[(3*r+c)*PX_W +: PX_W] = img[(y-1+r)*w + (x-1+c)];
        e.x = DIM_W'(x);
        e.y = DIM_W'(y);
        e.last = (x == w-2) && (y == h-2);
        expq.push_back(e);
      end
    do_start(w, h);
    checks++;
    if (busy !== 1'b1) begin errors++; $display("[TB] FAIL %s busy_after_start got %b want 1", name, busy); end
    idx = 0; nwin = 0; cyc = 0; budget = 50 + 8*w*h;
    fd_exp = 1'b0; valid_exp = 1'b0; hold_prev = 1'b0; finished = 1'b0;
    held = e;
    while (!finished && cyc < budget) begin
      cyc++;
      checks++;
      if (frame_done !== fd_exp) begin errors++; $display("[TB] FAIL %s frame_done got %b want %b", name, frame_done, fd_exp); end
      if (fd_exp) begin
        finished = 1'b1;
        checks++;
        if (busy !== 1'b0) begin errors++; $display("[TB] FAIL %s busy_after_done got %b want 0", name, busy); end
      end else begin
        if (valid_exp) begin
          checks++;
          if (out_valid !== 1'b1) begin errors++; $display("[TB] FAIL %s window_latency out_valid got %b want 1", name, out_valid); end
        end
        if (hold_prev) begin
          checks++;
          if (out_valid !== 1'b1 || out_window !== held.win || out_x !== held.x || out_y !== held.y || out_last !== held.last) begin
            errors++;
            $display("[TB] FAIL %s hold_stable got v=%b x=%0d y=%0d l=%b want v=1 x=%0d y=%0d l=%b", name, out_valid, out_x, out_y, out_last, held.x, held.y, held.last);
          end
        end
        in_valid  = (idx < w*h) && (rdy_mode == 0 || $urandom_range(0, 3) != 0);
        in_pixel  = in_valid ? img[idx] : PX_W'($urandom);
        out_ready = (rdy_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
        #1;
        if (out_valid && !out_ready) begin
          checks++;
          if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL %s in_ready_while_held got %b want 0", name, in_ready); end
        end
        if (rdy_mode == 0 && idx < w*h) begin
          checks++;
          if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL %s throughput in_ready got %b want 1 at pixel %0d", name, in_ready, idx); end
        end
        fire_last = 1'b0;
        if (out_valid && out_ready) begin
          nwin++;
          checks++;
          if (expq.size() == 0) begin
            errors++;
            $display("[TB] FAIL %s extra_window got x=%0d y=%0d want none", name, out_x, out_y);
          end else begin
            e = expq.pop_front();
            if (out_window !== e.win || out_x !== e.x || out_y !== e.y || out_last !== e.last) begin
              errors++;
              $display("[TB] FAIL %s window got x=%0d y=%0d l=%b w=%h want x=%0d y=%0d l=%b w=%h", name, out_x, out_y, out_last, out_window, e.x, e.y, e.last, e.win);
            end
            fire_last = e.last;
          end
        end
        hold_prev = out_valid && !out_ready;
        held.win = out_window; held.x = out_x; held.y = out_y; held.last = out_last;
        valid_exp = 1'b0;
        if (in_valid && in_ready) begin
          px = idx % w;
          py = idx / w;
          valid_exp = (px >= 2) && (py >= 2);
          idx++;
        end
        fd_exp = fire_last;
        @(negedge tb_clk);
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    checks++;
    if (!finished) begin errors++; $display("[TB] FAIL %s timeout got %0d cycles want frame_done", name, cyc); end
    checks++;
    if (nwin != (w-2)*(h-2)) begin errors++; $display("[TB] FAIL %s window_count got %0d want %0d", name, nwin, (w-2)*(h-2)); end
  endtask

  task automatic test_reset();
    n_rst = 1'b0; start = 1'b0; clear = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    img_width = '0; img_height = '0; in_pixel = '0;
    repeat (2) @(negedge tb_clk);
    checks++;
    if ({in_ready, out_valid, out_last, frame_done, busy, cfg_error} !== 6'b0) begin
      errors++; $display("[TB] FAIL reset_flags got %b want 000000", {in_ready, out_valid, out_last, frame_done, busy, cfg_error});
    end
    checks++;
    if (out_window !== '0 || out_x !== '0 || out_y !== '0) begin
      errors++; $display("[TB] FAIL reset_data got x=%0d y=%0d w=%h want all 0", out_x, out_y, out_window);
    end
    n_rst = 1'b1;
    @(negedge tb_clk);
    checks++;
    if (busy !== 1'b0 || in_ready !== 1'b0) begin errors++; $display("[TB] FAIL idle_after_reset got busy=%b in_ready=%b want 0 0", busy, in_ready); end
  endtask

  task automatic test_reject();
    int dims [3][2] = '{'{2, 5}, '{5, 2}, '{MAXW+1, 5}};
    for (int i = 0; i < 3; i++) begin
      do_start(dims[i][0], dims[i][1]);
      checks++;
      if (cfg_error !== 1'b1 || busy !== 1'b0 || in_ready !== 1'b0) begin
        errors++; $display("[TB] FAIL reject_%0d got cfg_error=%b busy=%b in_ready=%b want 1 0 0", i, cfg_error, busy, in_ready);
      end
      @(negedge tb_clk);
      checks++;
      if (cfg_error !== 1'b0 || busy !== 1'b0) begin
        errors++; $display("[TB] FAIL reject_pulse_%0d got cfg_error=%b busy=%b want 0 0", i, cfg_error, busy);
      end
    end
  endtask

  task automatic test_clear();
    do_start(6, 6);
    in_valid = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      in_pixel = PX_W'($urandom);
      #1;
      checks++;
      if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL clear_feed in_ready got %b want 1", in_ready); end
      @(negedge tb_clk);
    end
    in_valid = 1'b0;
    clear = 1'b1; start = 1'b1; img_width = DIM_W'(3); img_height = DIM_W'(3);
    @(negedge tb_clk);
    clear = 1'b0; start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (busy !== 1'b0 || frame_done !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b0) begin
        errors++; $display("[TB] FAIL after_clear got busy=%b fd=%b ov=%b ir=%b want 0 0 0 0", busy, frame_done, out_valid, in_ready);
      end
      @(negedge tb_clk);
    end
    run_frame(4, 3, 1, 1, "after_clear");
  endtask

  task automatic test_async_reset();
    do_start(3, 3);
    in_valid = 1'b1; out_ready = 1'b0;
    for (int i = 0; i < 9; i++) begin
      in_pixel = PX_W'($urandom);
      @(negedge tb_clk);
    end
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1) begin errors++; $display("[TB] FAIL pending_before_reset out_valid got %b want 1", out_valid); end
    #2 n_rst = 1'b0;
    #1;
    checks++;
    if ({in_ready, out_valid, out_last, frame_done, busy, cfg_error} !== 6'b0 || out_window !== '0 || out_x !== '0 || out_y !== '0) begin
      errors++; $display("[TB] FAIL async_reset got flags=%b x=%0d y=%0d want all 0", {in_ready, out_valid, out_last, frame_done, busy, cfg_error}, out_x, out_y);
    end
    @(negedge tb_clk);
    n_rst = 1'b1;
    @(negedge tb_clk);
    checks++;
    if (busy !== 1'b0 || in_ready !== 1'b0) begin errors++; $display("[TB] FAIL needs_new_start got busy=%b in_ready=%b want 0 0", busy, in_ready); end
    run_frame(3, 3, 0, 0, "post_reset");
  endtask

  task automatic test_single();      run_frame(3, 3, 0, 0, "single_3x3");            endtask
  task automatic test_stream();      run_frame(5, 4, 0, 0, "stream_5x4");            endtask
  task automatic test_backpressure(); run_frame(5, 4, 0, 1, "backpressure_5x4");     endtask
  task automatic test_random_frames();
    run_frame(7, 5, 1, 1, "random_7x5");
    run_frame(3, 6, 1, 0, "random_3x6");
    run_frame(MAXW, 3, 1, 1, "max_width");
  endtask
  task automatic test_back_to_back();
    run_frame(4, 4, 1, 0, "b2b_first");
    run_frame(4, 4, 1, 0, "b2b_second");
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog got no finish want finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_single();
    test_stream();
    test_backpressure();
    test_random_frames();
    test_back_to_back();
    test_reject();
    test_clear();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pixel_window_buffer.md
# pixel_window_buffer

Parametrised 3x3 sliding-window generator for the edge-detection datapath. It accepts a row-major pixel stream from the master read engine and holds the two previous image rows in internal line buffers. For every interior pixel it emits one 3x3 neighbourhood to the convolution stage. Channel count, pixel width and maximum image width are generic. Downstream backpressure is fully supported.

## Interface

- PIXEL_W, 8, bits per colour channel
- NUM_CH, 3, channels per pixel (R,G,B)
- MAX_WIDTH, 2500, largest supported image width; sets line-buffer depth
- DIM_W, 16, width of dimension and coordinate fields
- clk  in  1  system clock, rising edge
- n_rst  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse; latches img_width/img_height and begins a frame
- clear  in  1  synchronous abort, returns to IDLE
- img_width  in  DIM_W  frame width in pixels
- img_height  in  DIM_W  frame height in pixels
- in_valid  in  1  in_pixel valid
- in_ready  out  1  block accepts in_pixel this cycle
- in_pixel  in  NUM_CH*PIXEL_W  pixel; channel 0 in the LSBs
- out_valid  out  1  out_window valid
- out_ready  in  1  downstream accepts out_window
- out_window  out  9*NUM_CH*PIXEL_W  window; element k=3r+c occupies slice k (r=0 top/oldest row, c=0 leftmost); centre is k=4
- out_x, out_y  out  DIM_W each  image coordinates of the window centre
- out_last  out  1  marks the final window of the frame
- frame_done  out  1  one-cycle pulse after the final window is accepted
- busy  out  1  a frame is in progress
- cfg_error  out  1  one-cycle pulse when a start is rejected

## Operation

- States:
  - IDLE: wait for start.
  - STREAM: accept pixels.
  - FLUSH: final window is pending.
- In IDLE, start with 3 <= width <= MAX_WIDTH and height >= 3: latch the dimensions, set col=row=0, go to STREAM. busy=1.
- In IDLE, start with an illegal dimension: pulse cfg_error the next cycle and stay in IDLE.
- start outside IDLE is ignored.
- in_ready = (state==STREAM) && (!out_valid || out_ready). This is a single output register with pass-through on accept.
- On an accepted pixel p at (col,row):
  - Read A=lb0[col] (row-1) and B=lb1[col] (row-2).
  - Write lb1[col]<=A and lb0[col]<=p.
  - Shift the column {B,A,p} into the 3-column window register; the new column becomes c=2.
- A window is produced when row>=2 && col>=2.
  - Load out_window, set out_x=col-1, out_y=row-1, out_valid=1.
  - Set out_last=1 when col==W-1 && row==H-1.
- Counters: col increments and wraps to 0 at W-1, which increments row. Windows never span rows because col>=2 guarantees three fresh columns.
- After the last pixel is accepted, go to FLUSH.
- When out_valid && out_ready && out_last: clear out_valid, pulse frame_done, go to IDLE, busy=0.
- Line-buffer contents are never cleared; stale data is never emitted (row<2 gating).
- Output count per frame is exactly (H-2)*(W-2).
- Output order is row-major by (out_y, out_x).
- clear in any state:
  - Next state IDLE.
  - out_valid, out_last, busy go to 0.
  - Any pending window is discarded.
  - No frame_done pulse.
  - clear has priority over start in the same cycle.
- Line buffers: two MAX_WIDTH x NUM_CH*PIXEL_W arrays. Read and write happen in the same cycle at the same address with read-before-write semantics.

## Timing

- Reset values: in_ready 0, out_valid 0, out_window 0, out_x 0, out_y 0, out_last 0, frame_done 0, busy 0, cfg_error 0; state IDLE, col=row=0.
- start at edge N: state STREAM and busy=1 after edge N; in_ready can be high in cycle N+1.
- Latency: pixel accepted at edge N, its window valid after edge N (visible in cycle N+1).
- Throughput: one pixel and one window per cycle with out_ready held at 1.
- Holding: while out_valid && !out_ready, out_window, out_x, out_y and out_last are stable and in_ready=0.
- Pixel stall: in_valid low is a pure stall; no state changes.
- frame_done: asserted the cycle after the final handshake, for exactly one cycle.
- cfg_error: asserted the cycle after the rejected start, for exactly one cycle.
- Reset mid-frame: all outputs return to reset values immediately (asynchronous); the next frame needs a new start.

## Test plan

- 3x3 frame, pixel value = raster index (channels equal), out_ready=1: exactly one window with elements 0..8 in slices 0..8, out_x=out_y=1, out_last=1; frame_done one cycle after the handshake.
- 5x4 frame, continuous in_valid/out_ready: 6 windows with centres (1,1),(2,1),(3,1),(1,2),(2,2),(3,2); back-to-back out_valid within each row; centre = value at (x,y).
- Same frame, out_ready toggled pseudo-randomly: identical 6-window sequence; no drops or duplicates; outputs stable whenever out_valid && !out_ready.
- Rejected starts: start with width=2, then height=2, then width=MAX_WIDTH+1: each pulses cfg_error once; busy and in_ready stay 0.
- clear after 7 pixels of a 6x6 frame, then start with a 4x3 frame: no frame_done for the aborted frame; exactly 2 correct windows and frame_done for the new one.
- n_rst low mid-frame, then a 3x3 frame: all outputs 0 during reset; correct single window afterwards.
